aes_sbox_array: RTL and testbench

Multi-lane, time-multiplexed AES byte-substitution engine performing SubBytes or InvSubBytes on a LANES-byte word with a valid/ready handshake. It uses SBOXES physical dual-mode S-box instances and processes the word over LANES/SBOXES cycles, so area can be traded against latency. Forward or inverse mode is selected per transaction. The block sits between the round-state register and ShiftRows/InvShiftRows in the cipher/decipher datapath, and replaces per-byte S-box instantiation there.

---
 rtl/aes_pkg.sv | 49 ++++
 rtl/aes_sbox_dual.sv | 16 +
 rtl/aes_sbox_array.sv | 127 ++++++++++++
 tb/tb_aes_sbox_array.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES byte-substitution engine: the FIPS-197
// forward and inverse S-box tables and the engine's state enumeration.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_dual.sv
// Single combinational S-box that performs either the forward or the inverse
// byte substitution, chosen by the inv input.
module aes_sbox_dual
  import aes_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  // Table lookup; the mode bit picks which of the two tables drives the output.
  always_comb begin
    dout = inv ? SBOX_INV[din] : SBOX_FWD[din];
  end

endmodule

// File: rtl/aes_sbox_array.sv
// Time-multiplexed AES SubBytes/InvSubBytes engine. A captured word is
// substituted in place, SBOXES bytes per cycle, over LANES/SBOXES beats, then
// held on out_data until the consumer takes it.
module aes_sbox_array
  import aes_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int SBOXES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);

  localparam int BEATS  = LANES / SBOXES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // A lane count of zero or an S-box count that does not split the word
  // evenly has no meaningful schedule, so refuse to elaborate.
  if (LANES < 1) begin : g_bad_lanes
    $error("aes_sbox_array: LANES must be at least 1");
  end
  if (SBOXES < 1 || (LANES % SBOXES) != 0) begin : g_bad_sboxes
    $error("aes_sbox_array: SBOXES must divide LANES");
  end

  state_t              state;
  state_t              state_next;
  logic [8*LANES-1:0]  buffer;
  logic [BEAT_W-1:0]   beat;
  logic                inv_q;
  logic [7:0]          sbox_in  [SBOXES];
  logic [7:0]          sbox_out [SBOXES];

  // S-box j always works on byte beat*SBOXES+j of the buffer.
  for (genvar j = 0; j < SBOXES; j++) begin : g_sbox
    assign sbox_in[j] = buffer[8*(int'(beat)*SBOXES + j) +: 8];

    aes_sbox_dual u_sbox (
      .din  (sbox_in[j]),
      .inv  (inv_q),
      .dout (sbox_out[j])
    );
  end

  assign out_data = buffer;

  // State register; reset drops any in-flight word at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sequencing IDLE -> BUSY -> DONE -> IDLE plus the handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (beat == LAST_BEAT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word buffer, mode latch and beat counter: capture on accept, then write
  // each beat's substituted bytes back into the same positions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer <= '0;
      beat   <= '0;
      inv_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            buffer <= in_data;
            inv_q  <= in_inv;
            beat   <= '0;
          end
        end
        BUSY: begin
          for (int j = 0; j < SBOXES; j++) begin
            buffer[8*(int'(beat)*SBOXES + j) +: 8] <= sbox_out[j];
          end
          if (beat != LAST_BEAT) begin
            beat <= beat + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_sbox_array.sv
// Self-checking bench for aes_sbox_array: directed cases, backpressure,
// mid-transaction reset and randomized words against a GF(2^8) reference.
module tb_aes_sbox_array;

  localparam int LANES  = 16;
  localparam int SBOXES = 4;
  localparam int BEATS  = LANES / SBOXES;
  localparam int W      = 8 * LANES;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_inv    = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [W-1:0] out_data;

  int vectorCount     = 0;
  int miscompareCount = 0;
  int cycle           = 0;
  int acceptCycle     = 0;

  logic [7:0] fwdTab [256];
  logic [7:0] invTab [256];

  aes_sbox_array #(.LANES(LANES), .SBOXES(SBOXES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse by search; zero maps to zero.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    for (int b = 1; b < 256; b++) begin
      if (gmul(a, 8'(b)) == 8'h01) return 8'(b);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  // S-box value = affine transform of the field inverse.
  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [W-1:0] refWord(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      r[8*k +: 8] = inv ? invTab[d[8*k +: 8]] : fwdTab[d[8*k +: 8]];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] randWord();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; offers one word and returns at the negedge after
  // the accepting edge, with garbage left on the input bus.
  task automatic applyStimulus(input logic [W-1:0] d, input logic inv);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", W'(in_ready), W'(1));
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = randWord();
    in_inv   = ~inv;
    acceptCycle = cycle;
    checkOutput("accept_busy", W'(busy), W'(1));
  endtask

  // Waits for the result, checks latency and data, optionally stalls the
  // consumer while poking the input side, then completes the handshake.
  task automatic collectOutput(input logic [W-1:0] exp, input int stall, input bit pulse,
                               input string tag, output logic [W-1:0] got);
    int n;
    n = 0;
    got = '0;
    while (!out_valid && n < 100) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    if (!out_valid) begin
      checkOutput({tag, "_timeout"}, W'(out_valid), W'(1));
      return;
    end
    got = out_data;
    checkOutput({tag, "_latency"}, W'(cycle - acceptCycle), W'(BEATS));
    checkOutput({tag, "_data"}, out_data, exp);
    checkOutput({tag, "_busy_done"}, W'(busy), W'(1));
    for (int i = 0; i < stall; i++) begin
      if (pulse) begin
        in_valid = ~in_valid;
        in_data  = randWord();
        in_inv   = ~in_inv;
      end
      @(negedge clk);
      checkOutput({tag, "_hold_data"}, out_data, exp);
      checkOutput({tag, "_hold_flags"}, W'({out_valid, in_ready}), W'(2'b10));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_released"}, W'({out_valid, in_ready, busy}), W'(3'b010));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] res;
    logic [W-1:0] exp;
    logic         inv;

    for (int i = 0; i < 256; i++) fwdTab[i] = affine(gfInv(8'(i)));
    for (int i = 0; i < 256; i++) invTab[fwdTab[i]] = 8'(i);

    // Outputs while reset is held.
    @(negedge clk);
    checkOutput("reset_in_ready", W'(in_ready), W'(1));
    checkOutput("reset_out_valid", W'(out_valid), W'(0));
    checkOutput("reset_busy", W'(busy), W'(0));
    checkOutput("reset_out_data", out_data, '0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero word becomes all 0x63.
    applyStimulus('0, 1'b0);
    collectOutput({LANES{8'h63}}, 0, 1'b0, "zeros", res);

    // Known bytes, then inverse of the result restores the input.
    w   = {{(LANES-3){8'h00}}, 8'hff, 8'h01, 8'h53};
    exp = {{(LANES-3){8'h63}}, 8'h16, 8'h7c, 8'hed};
    applyStimulus(w, 1'b0);
    collectOutput(exp, 1, 1'b0, "known_fwd", res);
    applyStimulus(res, 1'b1);
    collectOutput(w, 2, 1'b0, "known_inv", res);

    // Round trip of a counting pattern.
    w = 128'h00112233445566778899aabbccddeeff;
    applyStimulus(w, 1'b0);
    collectOutput(refWord(w, 1'b0), 0, 1'b0, "trip_fwd", res);
    applyStimulus(res, 1'b1);
    collectOutput(w, 0, 1'b0, "trip_inv", res);

    // Long stall with input traffic; the offered words must be ignored.
    w = randWord();
    applyStimulus(w, 1'b0);
    collectOutput(refWord(w, 1'b0), 10, 1'b1, "bp", res);
    repeat (6) @(negedge clk);
    checkOutput("bp_no_capture", W'({out_valid, busy}), W'(2'b00));

    // Reset two beats into a word.
    applyStimulus(randWord(), 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", W'(out_valid), W'(0));
    checkOutput("midrst_out_data", out_data, '0);
    checkOutput("midrst_in_ready", W'(in_ready), W'(1));
    checkOutput("midrst_busy", W'(busy), W'(0));
    @(negedge clk);
    rst = 1'b0;
    applyStimulus('0, 1'b0);
    collectOutput({LANES{8'h63}}, 0, 1'b0, "after_rst", res);

    // Random words, modes, stalls and input noise.
    for (int t = 0; t < 1000; t++) begin
      w   = randWord();
      inv = 1'($urandom_range(0, 1));
      applyStimulus(w, inv);
      collectOutput(refWord(w, inv), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand", res);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
